vga_fb_reader: RTL

// Display-side consumer of the camera frame buffer. Generates 640x480@60 VGA timing on a
// 25 MHz pixel clock and reads the 160x120 RGB332 buffer through its read port. Upscales

---
 rtl/vga_fb_reader_pkg.sv | 37 +++
 rtl/vga_fb_reader_timing_gen.sv | 80 ++++++++
 rtl/vga_fb_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_reader_pkg.sv
// Shared VGA timing defaults, RGB332 field positions and the colour expansion helper
// used by the frame-buffer display path.
package vga_fb_reader_pkg;

  localparam int DEF_AW       = 15;
  localparam int DEF_FB_W     = 160;
  localparam int DEF_FB_H     = 120;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_RD_LAT   = 1;

  localparam int RGB_R_MSB = 7;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_B_MSB = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_rgb_t;

  // Widen each RGB332 field to 4 bits by replicating its top bits into the spare LSBs.
  function automatic vga_rgb_t rgb332_expand(input logic [7:0] d);
    vga_rgb_t c;
    c.r = {d[RGB_R_MSB -: 3], d[RGB_R_MSB]};
    c.g = {d[RGB_G_MSB -: 3], d[RGB_G_MSB]};
    c.b = {d[RGB_B_MSB -: 2], d[RGB_B_MSB -: 2]};
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_reader_timing_gen.sv
// vga_timing_gen: free-running pixel/line counters with raw (undelayed) sync, active and
// frame-start flags. Full counter values are exported only when FB_BORDER_EN is defined.
module vga_timing_gen
  import vga_fb_reader_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int HW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int VW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          pclk,
  input  logic          rst,
`ifdef FB_BORDER_EN
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
`endif
  output logic [1:0]    h_phase,
  output logic [1:0]    v_phase,
  output logic          h_active,
  output logic          line_end,
  output logic          frame_end,
  output logic          de_raw,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          frame_start_raw
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT_N  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_STEP   = HW'(1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT_N  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_STEP   = VW'(1);

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic          line_end_s;
  logic          v_last_s;

  assign line_end_s = (h_cnt_r == H_LAST);
  assign v_last_s   = (v_cnt_r == V_LAST);

  // Horizontal counter wraps every line; vertical counter steps on each horizontal wrap.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (line_end_s) begin
      h_cnt_r <= '0;
      v_cnt_r <= v_last_s ? '0 : (v_cnt_r + V_STEP);
    end else begin
      h_cnt_r <= h_cnt_r + H_STEP;
    end
  end

`ifdef FB_BORDER_EN
  assign h_cnt = h_cnt_r;
  assign v_cnt = v_cnt_r;
`endif
  assign h_phase         = h_cnt_r[1:0];
  assign v_phase         = v_cnt_r[1:0];
  assign h_active        = (h_cnt_r < H_ACT_N);
  assign line_end        = line_end_s;
  assign frame_end       = line_end_s && v_last_s;
  assign de_raw          = (h_cnt_r < H_ACT_N) && (v_cnt_r < V_ACT_N);
  assign hsync_raw       = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
  assign vsync_raw       = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
  assign frame_start_raw = (h_cnt_r == '0) && (v_cnt_r == '0);

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA scan-out of the 4x-upscaled RGB332 camera frame buffer.
// Optional macro FB_BORDER_EN paints a white one-pixel frame around the visible area.
module vga_fb_reader
  import vga_fb_reader_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int FB_W     = DEF_FB_W,
  parameter int FB_H     = DEF_FB_H,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic          pclk,
  input  logic          rst,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_de,
  output logic          frame_start
);

  localparam int L  = 2 + RD_LAT;
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  localparam logic [AW-1:0] FB_W_C       = AW'(FB_W);
  localparam logic [AW-1:0] ROW_BASE_MAX = AW'(FB_W * (FB_H - 1));
  localparam logic [AW-1:0] COL_STEP     = AW'(1);

  logic [1:0]    h_phase_s;
  logic [1:0]    v_phase_s;
  logic          h_active_s;
  logic          line_end_s;
  logic          frame_end_s;
  logic          de_raw_s;
  logic          hsync_raw_s;
  logic          vsync_raw_s;
  logic          frame_start_raw_s;
  logic [AW-1:0] row_base_r;
  logic [AW-1:0] col_r;
  logic [L-1:0]  hs_d_r;
  logic [L-1:0]  vs_d_r;
  logic [L-1:0]  de_d_r;
  logic [L-1:0]  fs_d_r;
  vga_rgb_t      pix_s;
  vga_rgb_t      pix_r;
`ifdef FB_BORDER_EN
  localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);
  logic [HW-1:0] h_cnt_s;
  logic [VW-1:0] v_cnt_s;
  logic [HW-1:0] h_d_r [L-1];
  logic [VW-1:0] v_d_r [L-1];
  logic          border_s;
`endif

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .pclk            (pclk),
    .rst             (rst),
`ifdef FB_BORDER_EN
    .h_cnt           (h_cnt_s),
    .v_cnt           (v_cnt_s),
`endif
    .h_phase         (h_phase_s),
    .v_phase         (v_phase_s),
    .h_active        (h_active_s),
    .line_end        (line_end_s),
    .frame_end       (frame_end_s),
    .de_raw          (de_raw_s),
    .hsync_raw       (hsync_raw_s),
    .vsync_raw       (vsync_raw_s),
    .frame_start_raw (frame_start_raw_s)
  );

  // row_base = (v>>2)*FB_W and col = h>>2, tracked incrementally alongside the counters.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      row_base_r <= '0;
      col_r      <= '0;
    end else if (line_end_s) begin
      col_r <= '0;
      if (frame_end_s) begin
        row_base_r <= '0;
      end else if ((v_phase_s == 2'b11) && (row_base_r != ROW_BASE_MAX)) begin
        row_base_r <= row_base_r + FB_W_C;
      end
    end else if (h_active_s && (h_phase_s == 2'b11)) begin
      col_r <= col_r + COL_STEP;
    end
  end

  // Read address register; parked at 0 outside the visible area.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      mem_rd_addr <= '0;
    end else begin
      mem_rd_addr <= de_raw_s ? (row_base_r + col_r) : '0;
    end
  end

  // Control delay lines matching the address-register plus buffer-read latency.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hs_d_r <= '1;
      vs_d_r <= '1;
      de_d_r <= '0;
      fs_d_r <= '0;
    end else begin
      hs_d_r <= {hs_d_r[L-2:0], hsync_raw_s};
      vs_d_r <= {vs_d_r[L-2:0], vsync_raw_s};
      de_d_r <= {de_d_r[L-2:0], de_raw_s};
      fs_d_r <= {fs_d_r[L-2:0], frame_start_raw_s};
    end
  end

`ifdef FB_BORDER_EN
  // Position delay line so the border test sees the coordinates of the returning pixel.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L - 1; i++) begin
        h_d_r[i] <= '0;
        v_d_r[i] <= '0;
      end
    end else begin
      h_d_r[0] <= h_cnt_s;
      v_d_r[0] <= v_cnt_s;
      for (int i = 1; i < L - 1; i++) begin
        h_d_r[i] <= h_d_r[i-1];
        v_d_r[i] <= v_d_r[i-1];
      end
    end
  end

  assign border_s = (h_d_r[L-2] == '0) || (h_d_r[L-2] == H_EDGE) ||
                    (v_d_r[L-2] == '0) || (v_d_r[L-2] == V_EDGE);
`endif

  // Colour select: buffer data is only looked at on its return cycle for a visible pixel.
  always_comb begin
    pix_s = '0;
    if (de_d_r[L-2]) begin
`ifdef FB_BORDER_EN
      if (border_s) begin
        pix_s = '{r: 4'hF, g: 4'hF, b: 4'hF};
      end else begin
        pix_s = rgb332_expand(mem_rd_data);
      end
`else
      pix_s = rgb332_expand(mem_rd_data);
`endif
    end else begin
      pix_s = '0;
    end
  end

  // Output colour register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pix_r <= '0;
    end else begin
      pix_r <= pix_s;
    end
  end

  assign vga_r       = pix_r.r;
  assign vga_g       = pix_r.g;
  assign vga_b       = pix_r.b;
  assign vga_hsync   = hs_d_r[L-1];
  assign vga_vsync   = vs_d_r[L-1];
  assign vga_de      = de_d_r[L-1];
  assign frame_start = fs_d_r[L-1];

endmodule
